alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Decode/issue stage that drives the integer ALU.
- Accepts one fetched RV32I instruction per handshake, together with its register-file operands and PC.
- Decodes OP, OP-IMM, LUI and AUIPC into the ALU control (fn, funct7) and operands (a, b).
- Holds the result in a single-entry valid/ready pipeline register feeding the execute stage. One-cycle latency; full throughput when downstream is ready.

Parameters:
- WIDTH, 32, datapath width of operands and PC. Must be 32 for RV32I immediate formats.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents instr/pc/rs1_data/rs2_data.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  RV32I instruction word.
- pc  in  WIDTH  address of instr.
- rs1_data  in  WIDTH  register-file value of instr[19:15].
- rs2_data  in  WIDTH  register-file value of instr[24:20].
- flush  in  1  synchronous kill of the held entry (branch redirect).
- out_valid  out  1  issued operation valid.
- out_ready  in  1  execute stage accepts.
- fn  out  alu_fn_t  ALU function, equal to funct3: ADD_SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL_SRA=101, OR=110, AND=111.
- funct7  out  funct7_t  ADD_SRL=7'b0000000, SUB_SRA=7'b0100000.
- a  out  WIDTH  ALU operand A.
- b  out  WIDTH  ALU operand B.
- rd  out  5  destination register.
- illegal  out  1  instruction is not a decodable ALU op.

Behaviour:
- Reset: out_valid=0; fn=ADD_SUB, funct7=ADD_SRL, a=b=0, rd=0, illegal=0. in_ready=1 in the first cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load occurs when in_valid && in_ready. Registered outputs update at the next edge and out_valid=1.
  - If out_ready && out_valid && !load, then out_valid goes to 0.
  - While out_valid && !out_ready, all outputs are held bit-stable.
  - in_valid may drop or change only when no load occurs; the upstream contract is valid-until-accepted.
- Precedence, highest first: rst, then flush, then load. flush forces out_valid=0 at the next edge and discards any same-cycle load; in_ready is unaffected by flush.
- Decode by opcode instr[6:0]:
  - OP (0110011): fn=funct3; funct7=instr[31:25]; a=rs1_data; b=rs2_data. Legal only if instr[31:25]=0000000, or instr[31:25]=0100000 with funct3 000 or 101.
  - OP-IMM (0010011): fn=funct3; a=rs1_data; b=sign-extended instr[31:20]; funct7=ADD_SRL (there is no SUBI; instr[30] is ignored).
    - funct3 001: requires instr[31:25]=0; b=zero-extended instr[24:20].
    - funct3 101: requires instr[31:25] to be 0000000 or 0100000; funct7=instr[31:25]; b=zero-extended instr[24:20].
  - LUI (0110111): fn=ADD_SUB, funct7=ADD_SRL, a=0, b={instr[31:12],12'b0}.
  - AUIPC (0010111): as LUI but a=pc.
  - Any other opcode, or a violated constraint: illegal=1, fn=ADD_SUB, funct7=ADD_SRL, a=b=0, rd=0. The entry is still issued (out_valid=1) so execute can trap.
- rd=instr[11:7] for legal instructions. rd=0 is passed through unchanged; suppressing the write is execute's job.
- All arithmetic is modulo 2^WIDTH. No arithmetic is performed here beyond extension and shifting.

Test Plan:
- ADD x3,x1,x2: instr=0x002081B3, rs1=5, rs2=0xFFFFFFFA, out_ready=1 -> next cycle: out_valid=1, fn=ADD_SUB, funct7=ADD_SRL, a=5, b=0xFFFFFFFA, rd=3, illegal=0.
- Immediates:
  - SUB 0x402081B3 -> funct7=SUB_SRA.
  - SRAI x5,x6,3 (0x40335293) -> fn=SRL_SRA, funct7=SUB_SRA, b=3, rd=5.
  - ADDI x1,x0,-1 (0xFFF00093) -> b=0xFFFFFFFF, funct7=ADD_SRL.
- LUI 0x123450B7 -> a=0, b=0x12345000. AUIPC with same immediate bits, pc=0x100 -> a=0x100, b=0x12345000.
- Backpressure: issue ADD, hold out_ready=0 for 3 cycles with a second instruction pending -> in_ready=0, outputs unchanged. Raise out_ready -> second instruction appears the next cycle, exactly once, with no loss or duplication. Back-to-back stream with out_ready=1 -> one issue per cycle.
- Illegal: 0x402091B3 (SLL with funct7 0100000) and opcode 0x7F -> out_valid=1, illegal=1, a=b=0, rd=0.
- Flush while stalled with a simultaneous load -> out_valid=0 next cycle and the loaded instruction is dropped. rst asserted mid-stall -> all outputs at reset values next edge.

Source files
------------

// File: rtl/alu_issue_if.sv
// Decode/issue bus: the upstream fetch handshake and the downstream
// issue to the integer ALU, carried on one interface.
interface alu_issue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;

    logic             out_valid;
    logic             out_ready;
    logic [2:0]       fn;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       rd;
    logic             illegal;

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, fn, funct7, a, b, rd, illegal
    );

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, fn, funct7, a, b, rd, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC into ALU
// control and operands, held in a single-entry valid/ready register.
module alu_issue #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    alu_issue_if.slave  bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] FN_ADD_SUB = 3'b000;
    localparam logic [2:0] FN_SLL     = 3'b001;
    localparam logic [2:0] FN_SRL_SRA = 3'b101;
    localparam logic [6:0] F7_ADD_SRL = 7'b0000000;
    localparam logic [6:0] F7_SUB_SRA = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] f7_field;

    logic             dec_legal;
    logic [2:0]       dec_fn;
    logic [6:0]       dec_funct7;
    logic [WIDTH-1:0] dec_a;
    logic [WIDTH-1:0] dec_b;

    logic             out_valid_q;
    logic [2:0]       fn_q;
    logic [6:0]       funct7_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [4:0]       rd_q;
    logic             illegal_q;

    logic load;

    assign opcode   = bus.instr[6:0];
    assign funct3   = bus.instr[14:12];
    assign f7_field = bus.instr[31:25];

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready;

    // Shift-immediate forms replace the I-type immediate with a zero-extended shamt.
    always_comb begin
        dec_legal  = 1'b0;
        dec_fn     = FN_ADD_SUB;
        dec_funct7 = F7_ADD_SRL;
        dec_a      = '0;
        dec_b      = '0;
        case (opcode)
            OPC_OP: begin
                dec_legal  = (f7_field == F7_ADD_SRL) ||
                             ((f7_field == F7_SUB_SRA) &&
                              ((funct3 == FN_ADD_SUB) || (funct3 == FN_SRL_SRA)));
                dec_fn     = funct3;
                dec_funct7 = f7_field;
                dec_a      = bus.rs1_data;
                dec_b      = bus.rs2_data;
            end
            OPC_OP_IMM: begin
                dec_legal = 1'b1;
                dec_fn    = funct3;
                dec_a     = bus.rs1_data;
                dec_b     = WIDTH'($signed(bus.instr[31:20]));
                if (funct3 == FN_SLL) begin
                    dec_legal = (f7_field == F7_ADD_SRL);
                    dec_b     = WIDTH'(bus.instr[24:20]);
                end else if (funct3 == FN_SRL_SRA) begin
                    dec_legal  = (f7_field == F7_ADD_SRL) || (f7_field == F7_SUB_SRA);
                    dec_funct7 = f7_field;
                    dec_b      = WIDTH'(bus.instr[24:20]);
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_b     = WIDTH'({bus.instr[31:12], 12'b0});
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_a     = bus.pc;
                dec_b     = WIDTH'({bus.instr[31:12], 12'b0});
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Illegal entries are still issued, with neutral control so execute can trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            fn_q        <= FN_ADD_SUB;
            funct7_q    <= F7_ADD_SRL;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            illegal_q   <= !dec_legal;
            if (dec_legal) begin
                fn_q     <= dec_fn;
                funct7_q <= dec_funct7;
                a_q      <= dec_a;
                b_q      <= dec_b;
                rd_q     <= bus.instr[11:7];
            end else begin
                fn_q     <= FN_ADD_SUB;
                funct7_q <= F7_ADD_SRL;
                a_q      <= '0;
                b_q      <= '0;
                rd_q     <= '0;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.fn        = fn_q;
    assign bus.funct7    = funct7_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.rd        = rd_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode vectors, backpressure,
// streaming, illegal encodings, flush and mid-stall reset.
module tb_alu_issue;
    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   failures;

    alu_issue_if #(.WIDTH(32)) bus ();

    alu_issue #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic vld, input logic [31:0] ins,
                                 input logic [31:0] pcv, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic ordy,
                                 input logic fl);
        bus.in_valid  = vld;
        bus.instr     = ins;
        bus.pc        = pcv;
        bus.rs1_data  = r1;
        bus.rs2_data  = r2;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkIssue(input string tag, input logic vld, input logic [2:0] efn,
                              input logic [6:0] ef7, input logic [31:0] ea,
                              input logic [31:0] eb, input logic [4:0] erd,
                              input logic eill);
        checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
        checkOutput({tag, ".fn"},        32'(bus.fn),        32'(efn));
        checkOutput({tag, ".funct7"},    32'(bus.funct7),    32'(ef7));
        checkOutput({tag, ".a"},         bus.a,              ea);
        checkOutput({tag, ".b"},         bus.b,              eb);
        checkOutput({tag, ".rd"},        32'(bus.rd),        32'(erd));
        checkOutput({tag, ".illegal"},   32'(bus.illegal),   32'(eill));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checkIssue("reset", 1'b0, 3'b000, 7'h00, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);

        // ADD x3,x1,x2
        applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'hFFFFFFFA, 1'b1, 1'b0);
        tick();
        checkIssue("add", 1'b1, 3'b000, 7'h00, 32'd5, 32'hFFFFFFFA, 5'd3, 1'b0);

        applyStimulus(1'b1, 32'h402081B3, 32'h0, 32'd9, 32'd4, 1'b1, 1'b0);
        tick();
        checkIssue("sub", 1'b1, 3'b000, 7'h20, 32'd9, 32'd4, 5'd3, 1'b0);

        applyStimulus(1'b1, 32'h40335293, 32'h0, 32'h80000000, 32'h0, 1'b1, 1'b0);
        tick();
        checkIssue("srai", 1'b1, 3'b101, 7'h20, 32'h80000000, 32'd3, 5'd5, 1'b0);

        applyStimulus(1'b1, 32'hFFF00093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkIssue("addi", 1'b1, 3'b000, 7'h00, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b0);

        applyStimulus(1'b1, 32'h123450B7, 32'h100, 32'h55, 32'h66, 1'b1, 1'b0);
        tick();
        checkIssue("lui", 1'b1, 3'b000, 7'h00, 32'h0, 32'h12345000, 5'd1, 1'b0);

        applyStimulus(1'b1, 32'h12345097, 32'h100, 32'h55, 32'h66, 1'b1, 1'b0);
        tick();
        checkIssue("auipc", 1'b1, 3'b000, 7'h00, 32'h100, 32'h12345000, 5'd1, 1'b0);

        applyStimulus(1'b1, 32'h402091B3, 32'h0, 32'h11, 32'h22, 1'b1, 1'b0);
        tick();
        checkIssue("ill_sll", 1'b1, 3'b000, 7'h00, 32'h0, 32'h0, 5'd0, 1'b1);

        applyStimulus(1'b1, 32'h00000FFF, 32'h0, 32'h11, 32'h22, 1'b1, 1'b0);
        tick();
        checkIssue("ill_opc", 1'b1, 3'b000, 7'h00, 32'h0, 32'h0, 5'd0, 1'b1);

        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("drain.out_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: ADD stalls for three cycles with a SUB waiting.
        applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'hFFFFFFFA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h402081B3, 32'h0, 32'd7, 32'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall.in_ready", 32'(bus.in_ready), 32'd0);
            checkIssue("stall", 1'b1, 3'b000, 7'h00, 32'd5, 32'hFFFFFFFA, 5'd3, 1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("release.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkIssue("release", 1'b1, 3'b000, 7'h20, 32'd7, 32'd2, 5'd3, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("no_dup.out_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back stream: ADDI x1..x4, one issue per cycle.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 32'h00100013 | (32'(i) << 7), 32'h0, 32'(i * 10),
                          32'h0, 1'b1, 1'b0);
            checkOutput("stream.in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            checkIssue("stream", 1'b1, 3'b000, 7'h00, 32'(i * 10), 32'd1, 5'(i), 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_end.out_valid", 32'(bus.out_valid), 32'd0);

        // Flush wins over a same-cycle load.
        applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd6, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h123450B7, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("flush.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("flush.out_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("flush_drop.out_valid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a stall.
        applyStimulus(1'b1, 32'h123450B7, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checkIssue("pre_rst", 1'b1, 3'b000, 7'h00, 32'h0, 32'h12345000, 5'd1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIssue("mid_rst", 1'b0, 3'b000, 7'h00, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("mid_rst.in_ready", 32'(bus.in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
